gray2rgb565: RTL and testbench

//  Display-side counterpart of the 565-to-gray converter. Takes the 8-bit grayscale

---
 rtl/gray2rgb565_if.sv | 24 ++
 rtl/gray2rgb565.sv | 142 ++++++++++++++
 tb/tb_gray2rgb565.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gray2rgb565_if.sv
// Downstream pixel bus of the gray-to-RGB565 expander: pixel, frame address
// and a valid/ready handshake.
interface gray2rgb565_if #(
    parameter int ADDR_W = 17
);
    logic [15:0]       pixel_out;
    logic [ADDR_W-1:0] pixel_addr_out;
    logic              pixel_valid_out;
    logic              pixel_ready_in;

    modport master (
        output pixel_out,
        output pixel_addr_out,
        output pixel_valid_out,
        input  pixel_ready_in
    );

    modport slave (
        input  pixel_out,
        input  pixel_addr_out,
        input  pixel_valid_out,
        output pixel_ready_in
    );
endinterface

// File: rtl/gray2rgb565.sv
// Expands an 8-bit grayscale pixel stream to RGB565, buffers it in a small FIFO
// tagged with each pixel's linear frame address, and drains it on valid/ready.
module gray2rgb565 #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int ADDR_W     = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [7:0]         gray_in,
    input  logic               pixel_valid_in,
    input  logic               frame_done_in,
    gray2rgb565_if.master      pix_if,
    output logic               frame_done_out,
    output logic               overflow_out
);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int AC_W       = ADDR_W + 1;
    localparam int FRAME_SIZE = H_ACTIVE * V_ACTIVE;
    localparam int WORD_W     = 16 + ADDR_W;

    typedef enum logic [1:0] {
        ST_WAIT_START = 2'd0,
        ST_RUN        = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    function automatic logic [15:0] gray_to_565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    // One bit wider than an address so the counter can sit at FRAME_SIZE.
    logic [AC_W-1:0]     r_addr_cnt;
    logic                r_overflow;
    logic                r_frame_done;

    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic                w_frame_start;
    logic [WORD_W-1:0]   w_rd_word;

    assign w_valid       = (r_count != CNT_W'(0));
    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop         = w_valid & pix_if.pixel_ready_in;
    assign w_push_req    = (r_state == ST_RUN) & pixel_valid_in & ~frame_done_in;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a pixel.
    assign w_push        = w_push_req & (~w_full | w_pop) & (r_addr_cnt < AC_W'(FRAME_SIZE));
    assign w_drop        = w_push_req & ~w_push;
    assign w_frame_start = (r_state == ST_WAIT_START) & ~frame_done_in;
    assign w_rd_word     = r_mem[r_rd_ptr];

    assign pix_if.pixel_valid_out = w_valid;
    assign pix_if.pixel_out       = w_valid ? w_rd_word[WORD_W-1:ADDR_W] : 16'h0000;
    assign pix_if.pixel_addr_out  = w_valid ? w_rd_word[ADDR_W-1:0] : ADDR_W'(0);
    assign frame_done_out         = r_frame_done;
    assign overflow_out           = r_overflow;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_WAIT_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; FLUSH waits for the FIFO to drain completely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_START: begin
                if (!frame_done_in) w_state_nxt = ST_RUN;
                else                w_state_nxt = ST_WAIT_START;
            end
            ST_RUN: begin
                if (frame_done_in) w_state_nxt = ST_FLUSH;
                else               w_state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                if (r_count == CNT_W'(0)) w_state_nxt = ST_WAIT_START;
                else                      w_state_nxt = ST_FLUSH;
            end
            default: w_state_nxt = ST_WAIT_START;
        endcase
    end

    // FIFO storage: converted pixel and its address, written on accepted push.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {gray_to_565(gray_in), r_addr_cnt[ADDR_W-1:0]};
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame address counter, sticky overflow flag and drain-complete pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr_cnt   <= AC_W'(0);
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_addr_cnt <= AC_W'(0);
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_addr_cnt <= r_addr_cnt + AC_W'(1);
                if (w_drop) r_overflow <= 1'b1;
            end
            r_frame_done <= (r_state == ST_FLUSH) && (r_count == CNT_W'(0));
        end
    end
endmodule

// File: tb/tb_gray2rgb565.sv
// Self-checking bench for gray2rgb565: a queue-based reference model is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_gray2rgb565;
    localparam int DEPTH = 8;
    localparam int H     = 320;
    localparam int V     = 240;
    localparam int FRAME = H * V;
    localparam int AW    = 17;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gray;
    logic       pv;
    logic       fd;
    logic       ready;
    logic       frame_done_out;
    logic       overflow_out;

    gray2rgb565_if #(.ADDR_W(AW)) pix_if ();
    assign pix_if.pixel_ready_in = ready;

    gray2rgb565 #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .gray_in        (gray),
        .pixel_valid_in (pv),
        .frame_done_in  (fd),
        .pix_if         (pix_if),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int dut_pops = 0;
    int fdo_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected pixel value from the channel widths, arithmetic form.
    function automatic logic [15:0] expect_565(input int g);
        int r5, g6, b5;
        r5 = g / 8;
        g6 = g / 4;
        b5 = g / 8;
        return 16'(r5 * 2048 + g6 * 32 + b5);
    endfunction

    typedef struct packed {
        logic [15:0] pix;
        logic [31:0] addr;
    } ent_t;

    ent_t m_q[$];
    int   m_state = 0;   // 0 waiting for frame, 1 accepting, 2 draining
    int   m_addr  = 0;
    bit   m_ovf   = 1'b0;
    bit   m_fdo   = 1'b0;
    bit   m_zero  = 1'b0;

    // Model update on each rising edge from the inputs held across it.
    initial begin
        forever begin
            bit   pop, full, push;
            int   pre_size;
            ent_t e;
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_state = 0; m_addr = 0; m_ovf = 1'b0; m_fdo = 1'b0; m_zero = 1'b1;
            end else begin
                pre_size = m_q.size();
                pop  = (pre_size != 0) && ready;
                full = (pre_size == DEPTH);
                push = 1'b0;
                m_fdo = 1'b0; m_zero = 1'b0;
                if (m_state == 0) begin
                    if (!fd) begin m_state = 1; m_addr = 0; m_ovf = 1'b0; end
                end else if (m_state == 1) begin
                    if (pv && !fd) begin
                        if ((!full || pop) && m_addr < FRAME) push = 1'b1;
                        else m_ovf = 1'b1;
                    end
                    if (fd) m_state = 2;
                end else begin
                    if (pre_size == 0) begin m_fdo = 1'b1; m_state = 0; end
                end
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    e.pix = expect_565(int'(gray));
                    e.addr = 32'(m_addr);
                    m_q.push_back(e);
                    m_addr++;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", 32'(pix_if.pixel_valid_out), 32'(m_q.size() != 0));
                if (m_q.size() != 0) begin
                    check("pixel", 32'(pix_if.pixel_out), 32'(m_q[0].pix));
                    check("addr", 32'(pix_if.pixel_addr_out), m_q[0].addr);
                end else if (m_zero) begin
                    check("rst_pixel", 32'(pix_if.pixel_out), 32'h0);
                    check("rst_addr", 32'(pix_if.pixel_addr_out), 32'h0);
                end
                check("frame_done", 32'(frame_done_out), 32'(m_fdo));
                check("overflow", 32'(overflow_out), 32'(m_ovf));
                if (pix_if.pixel_valid_out && ready) dut_pops++;
                if (frame_done_out) fdo_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fdo(input string name, input int bound, input bit toggle_ready);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (toggle_ready) ready = ~ready;
            if (frame_done_out) begin got = 1'b1; break; end
        end
        check(name, 32'(got), 32'h1);
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; fd = 1'b0; ready = 1'b1; gray = 8'h00;
        step();
        chk_en = 1'b1;
        step();
        check("reset_valid", 32'(pix_if.pixel_valid_out), 32'h0);
        check("reset_pixel", 32'(pix_if.pixel_out), 32'h0);
        check("reset_ovf", 32'(overflow_out), 32'h0);

        // Directed conversion values
        rst = 1'b0;
        step();
        pv = 1'b1; gray = 8'hFF; step();
        check("t1_ff", 32'(pix_if.pixel_out), 32'hFFFF);
        check("t1_addr0", 32'(pix_if.pixel_addr_out), 32'h0);
        gray = 8'h00; step();
        check("t1_00", 32'(pix_if.pixel_out), 32'h0000);
        check("t1_addr1", 32'(pix_if.pixel_addr_out), 32'h1);
        gray = 8'h80; step();
        check("t1_80", 32'(pix_if.pixel_out), 32'h8410);
        check("t1_addr2", 32'(pix_if.pixel_addr_out), 32'h2);
        pv = 1'b0; step();
        check("t1_empty", 32'(pix_if.pixel_valid_out), 32'h0);
        fd = 1'b1; wait_fdo("t1_fdo", 20, 1'b0);
        fd = 1'b0; step();

        // Full frame, then one pixel beyond the frame size
        dut_pops = 0;
        pv = 1'b1;
        for (int i = 0; i < FRAME; i++) begin gray = 8'($urandom); step(); end
        pv = 1'b0; step(); step();
        check("t2_no_ovf", 32'(overflow_out), 32'h0);
        check("t2_pops", 32'(dut_pops), 32'(FRAME));
        pv = 1'b1; step(); pv = 1'b0; step();
        check("t2_ovf_frame_end", 32'(overflow_out), 32'h1);
        fdo_seen = 0;
        fd = 1'b1; wait_fdo("t2_fdo", 20, 1'b0);
        step(); step();
        check("t2_one_pulse", 32'(fdo_seen), 32'h1);
        fd = 1'b0; step();

        // Overflow with ready held low
        ready = 1'b0; pv = 1'b1;
        for (int i = 0; i < 10; i++) begin gray = 8'($urandom); step(); end
        pv = 1'b0; step();
        check("t3_ovf", 32'(overflow_out), 32'h1);
        ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("t3_drained", 32'(pix_if.pixel_valid_out), 32'h0);
        fd = 1'b1; wait_fdo("t3_fdo", 20, 1'b0);
        fd = 1'b0; step();
        check("t3_ovf_cleared", 32'(overflow_out), 32'h0);

        // Full FIFO with simultaneous push and pop
        ready = 1'b0; pv = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin gray = 8'($urandom); step(); end
        ready = 1'b1; gray = 8'h5A; step();
        check("t6_no_ovf", 32'(overflow_out), 32'h0);
        dut_pops = 0; pv = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) step();
        check("t6_count", 32'(dut_pops), 32'(DEPTH));
        fd = 1'b1; wait_fdo("t6_fdo", 20, 1'b0);
        fd = 1'b0; step();

        // Flush with ready toggling
        ready = 1'b0; pv = 1'b1;
        for (int i = 0; i < 5; i++) begin gray = 8'($urandom); step(); end
        pv = 1'b0; fd = 1'b1; dut_pops = 0;
        wait_fdo("t4_fdo", 40, 1'b1);
        check("t4_pops_before_fdo", 32'(dut_pops), 32'h5);
        ready = 1'b1; fd = 1'b0; step();

        // Reset mid-frame with FIFO half full
        ready = 1'b0; pv = 1'b1;
        for (int i = 0; i < 4; i++) begin gray = 8'($urandom); step(); end
        pv = 1'b0; rst = 1'b1; fdo_seen = 0; step();
        check("t5_valid", 32'(pix_if.pixel_valid_out), 32'h0);
        check("t5_pixel", 32'(pix_if.pixel_out), 32'h0);
        check("t5_addr", 32'(pix_if.pixel_addr_out), 32'h0);
        rst = 1'b0; step();
        pv = 1'b1; gray = 8'h40; ready = 1'b1; step();
        check("t5_restart_addr", 32'(pix_if.pixel_addr_out), 32'h0);
        check("t5_restart_pixel", 32'(pix_if.pixel_out), 32'h4208);
        pv = 1'b0; step();
        check("t5_no_fdo", 32'(fdo_seen), 32'h0);
        fd = 1'b1; wait_fdo("t5_fdo", 20, 1'b0);

        // Randomized frames against the model
        for (int f = 0; f < 6; f++) begin
            fd = 1'b0; step();
            for (int c = 0; c < 200 + int'($urandom_range(0, 200)); c++) begin
                pv    = ($urandom_range(0, 3) != 0);
                gray  = 8'($urandom);
                ready = ($urandom_range(0, 2) != 0);
                rst   = ($urandom_range(0, 499) == 0);
                step();
            end
            rst = 1'b0; pv = 1'b1; fd = 1'b1;
            wait_fdo("rand_fdo", 100, 1'b1);
            ready = 1'b1; pv = 1'b0;
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
